// File: rtl/bank_wr_distributor.sv
// Steers one input word per handshake to one of 16 banks, filling a 16*DEPTH frame.
// Optional diagonal bank skew selected by defining BANK_SKEW_EN.
`ifndef D_width
`define D_width 32
`endif

module bank_wr_distributor #(
  parameter int DEPTH   = 16,
  parameter int A_width = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [`D_width-1:0]   D_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [15:0]           wr_en,
  output logic [A_width-1:0]    wr_addr,
  output logic [`D_width-1:0]   wr_data,
  output logic [4:0]            sel_in,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = A_width + 4;
  localparam logic [CW-1:0] LAST = CW'(16 * DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      cnt;
  logic [3:0]         col;
  logic [A_width-1:0] row;
  logic [3:0]         bank;
  logic               accept;

  assign col = cnt[3:0];
  assign row = cnt[CW-1:4];

`ifdef BANK_SKEW_EN
  // Diagonal skew: a column of rows lands in 16 distinct banks
  assign bank = col + row[3:0];
`else
  assign bank = col;
`endif

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FILL;
      FILL:    if (accept && cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      FILL: begin
        in_ready = ~start;
        busy     = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Restart from word 0 on start in IDLE or FILL; start in DONE is ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start && state != DONE) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      sel_in  <= '0;
    end else begin
      wr_en <= '0;
      if (accept) begin
        wr_en   <= 16'b1 << bank;
        wr_addr <= row;
        wr_data <= D_in;
        sel_in  <= {1'b0, bank};
      end
    end
  end

endmodule

// File: tb/tb_bank_wr_distributor.sv
// Randomized bench for bank_wr_distributor against a frame-level reference model.
// Literal checks pin the model at frame boundaries, abort and async reset.
`ifndef D_width
`define D_width 32
`endif

module tb_bank_wr_distributor;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = `D_width;
  localparam int NW    = 16 * DEPTH;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] D_in;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [4:0]    sel_in;
  logic          busy;
  logic          done;

  bank_wr_distributor #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .D_in     (D_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .sel_in   (sel_in),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit run = 0;

  // reference model state
  bit            m_active;
  bit            m_done;
  int            m_k;
  logic [15:0]   e_wr_en;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [4:0]    e_sel;

  logic [DW-1:0] mem [16][DEPTH];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bank_of(int k);
    int col, row;
    col = k % 16;
    row = (k / 16) % 16;
`ifdef BANK_SKEW_EN
    return (col + row) % 16;
`else
    return col + 0 * row;
`endif
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_k      = 0;
    e_wr_en  = '0;
    e_addr   = '0;
    e_data   = '0;
    e_sel    = '0;
  endtask

  task automatic model_step(bit st, bit v, logic [DW-1:0] d);
    bit acc;
    int b;
    acc = m_active && !st && v;
    e_wr_en = '0;
    if (acc) begin
      b       = bank_of(m_k);
      e_wr_en = 16'(1) << b;
      e_addr  = AW'(m_k / 16);
      e_data  = d;
      e_sel   = 5'(b);
    end
    if (m_done) begin
      m_done = 0;
    end else if (!m_active) begin
      if (st) begin
        m_active = 1;
        m_k      = 0;
      end
    end else if (st) begin
      m_k = 0;
    end else if (acc) begin
      m_k++;
      if (m_k == NW) begin
        m_active = 0;
        m_done   = 1;
        m_k      = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("wr_en", 64'(wr_en), 64'(e_wr_en));
      if (e_wr_en != 0) begin
        chk("wr_addr", 64'(wr_addr), 64'(e_addr));
        chk("wr_data", 64'(wr_data), 64'(e_data));
        chk("sel_in", 64'(sel_in), 64'(e_sel));
      end
      chk("in_ready", 64'(in_ready), 64'(m_active && !start));
      chk("busy", 64'(busy), 64'(m_active));
      chk("done", 64'(done), 64'(m_done));
      if (done) done_cnt++;
      for (int b = 0; b < 16; b++)
        if (wr_en[b]) mem[b][wr_addr] = wr_data;
    end
  end

  task automatic drive(bit st, bit v, logic [DW-1:0] d);
    start    = st;
    in_valid = v;
    D_in     = d;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step(start, in_valid, D_in);
    @(negedge clk);
    #1;
  endtask

  task automatic cyc(bit st, bit v, logic [DW-1:0] d);
    drive(st, v, d);
    step();
  endtask

  task automatic mem_clear();
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < DEPTH; r++)
        mem[b][r] = '1;
  endtask

  task automatic mem_check(string name);
    int errs;
    int col, k;
    errs = 0;
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < DEPTH; r++) begin
`ifdef BANK_SKEW_EN
        col = (b - (r % 16) + 16) % 16;
`else
        col = b;
`endif
        k = r * 16 + col;
        if (mem[b][r] !== DW'(k)) errs++;
      end
    chk(name, 64'(errs), 64'd0);
  endtask

  initial begin
    int d0, sent, guard;
    rst_n = 1'b0;
    drive(0, 0, '0);
    model_reset();
    mem_clear();
    @(posedge clk);
    run = 1;
    @(negedge clk);
    #1;
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // idle with valid but no start
    for (int i = 0; i < 10; i++) cyc(0, 1, DW'($urandom));
    chk("idle_ready", 64'(in_ready), 64'd0);

    // back-to-back frame, data = word index
    mem_clear();
    d0 = done_cnt;
    cyc(1, 0, '0);
    for (int k = 0; k < NW; k++) begin
      cyc(0, 1, DW'(k));
      if (k == 0) begin
        chk("w0_en", 64'(wr_en), 64'h1);
        chk("w0_addr", 64'(wr_addr), 64'd0);
      end
      if (k == 17) begin
`ifdef BANK_SKEW_EN
        chk("w17_en", 64'(wr_en), 64'h0004);
        chk("w17_sel", 64'(sel_in), 64'd2);
`else
        chk("w17_en", 64'(wr_en), 64'h0002);
        chk("w17_sel", 64'(sel_in), 64'd1);
`endif
        chk("w17_addr", 64'(wr_addr), 64'd1);
      end
    end
`ifdef BANK_SKEW_EN
    chk("last_en", 64'(wr_en), 64'h4000);
`else
    chk("last_en", 64'(wr_en), 64'h8000);
`endif
    chk("last_addr", 64'(wr_addr), 64'd15);
    chk("last_data", 64'(wr_data), 64'd255);
    chk("last_done", 64'(done), 64'd1);
    chk("last_busy", 64'(busy), 64'd0);
    cyc(0, 1, '0);
    chk("done_pulse", 64'(done), 64'd0);
    mem_check("frame_mem");
    chk("frame_done_cnt", 64'(done_cnt - d0), 64'd1);

    // gaps on every third cycle
    mem_clear();
    d0 = done_cnt;
    cyc(1, 0, '0);
    sent = 0;
    guard = 0;
    while (sent < NW && guard < 1000) begin
      if (guard % 3 == 2) begin
        cyc(0, 0, DW'($urandom));
      end else begin
        cyc(0, 1, DW'(sent));
        sent++;
      end
      guard++;
    end
    chk("gap_sent", 64'(sent), 64'(NW));
    chk("gap_done", 64'(done), 64'd1);
    cyc(0, 0, '0);
    mem_check("gap_mem");
    chk("gap_done_cnt", 64'(done_cnt - d0), 64'd1);

    // abort: restart after 20 words
    cyc(1, 0, '0);
    for (int k = 0; k < 20; k++) cyc(0, 1, DW'($urandom));
    drive(1, 1, DW'(32'h55));
    #1;
    chk("abort_ready", 64'(in_ready), 64'd0);
    step();
    chk("abort_no_wr", 64'(wr_en), 64'd0);
    cyc(0, 1, DW'(32'h77));
    chk("abort_w0_en", 64'(wr_en), 64'h1);
    chk("abort_w0_addr", 64'(wr_addr), 64'd0);

    // async reset mid frame
    cyc(1, 0, '0);
    for (int k = 0; k < 100; k++) cyc(0, 1, DW'($urandom));
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    d0 = done_cnt;
    drive(0, 1, '0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cyc(0, 1, DW'($urandom));
    chk("arst_no_done", 64'(done_cnt - d0), 64'd0);

    // random traffic with rare starts
    cyc(1, 0, '0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
          DW'($urandom));
    for (int i = 0; i < 3 * NW && !(done || !busy); i++)
      cyc(0, 1, DW'($urandom));
    cyc(0, 0, '0);
    cyc(0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_wr_distributor.md
# bank_wr_distributor

Write-side counterpart of the 16-bank output read multiplexer. It accepts one data word per handshake from a single input stream and steers each word to one of 16 memory banks. For every accepted word it generates a one-hot bank write enable, a shared row address and shared write data. It counts a frame of 16×DEPTH words and signals completion, so the bank array is filled before the read side starts selecting banks with its 5-bit select.

## Interface
Parameters:
- DEPTH, 16: words per bank (rows); power of two, ≥ 16.
- A_width, $clog2(DEPTH): row address width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  pulse; begins (or restarts) a frame.
- D_in  input  `D_width  input data word.
- in_valid  input  1  D_in valid.
- in_ready  output  1  block can accept D_in this cycle.
- wr_en  output  16  one-hot bank write enable; bit b → bank b.
- wr_addr  output  A_width  row address, shared by all banks.
- wr_data  output  `D_width  write data, shared by all banks.
- sel_in  output  5  bank index of the current write, {1'b0, bank}; same encoding as the read select.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, FILL, DONE.
  - IDLE: in_ready=0; start → FILL, word counter cnt ← 0.
  - FILL: in_ready = ~start.
    - Accept = in_valid & in_ready.
    - On accept: cnt ← cnt+1.
    - Accept with cnt == 16×DEPTH−1 → DONE.
    - start in FILL → cnt ← 0, stay in FILL (abort and restart). No word is accepted in that cycle; writes already issued are not undone.
  - DONE: done=1, in_ready=0 → IDLE unconditionally. start in DONE is ignored.
- cnt width: A_width+4 bits.
- Mapping of each accepted word: col = cnt[3:0], row = cnt[A_width+3:4].
  - bank = col (see Configuration for the skewed mapping).
  - wr_addr ← row; wr_data ← D_in; wr_en ← 1<<bank; sel_in ← {1'b0, bank}.
- No accept in a cycle → wr_en ← 0 next cycle. wr_addr, wr_data and sel_in hold their last values.
- busy = (state == FILL).

## Timing
- Reset values: state=IDLE, cnt=0, wr_en=0, wr_addr=0, wr_data=0, sel_in=0, done=0, in_ready=0, busy=0.
- Latency: write outputs are registered and appear exactly 1 cycle after the accepting edge. wr_en is high for exactly one cycle per accepted word.
- Throughput: 1 word/cycle while in_valid stays high; a full frame takes 16×DEPTH accepting cycles.
- done rises in the same cycle as the final wr_en pulse (1 cycle after the last accept). busy falls in that same cycle.
- in_ready depends combinationally on state and start only, never on in_valid.
- Wrap-around: the final word writes bank 15 (unskewed) at row DEPTH−1. cnt then clears to 0 on the next start.
- rst_n asserted mid-frame: all outputs return to their reset values immediately. The partial frame is discarded; no done is issued.

## Configuration
- BANK_SKEW_EN defined: bank = (col + row[3:0]) mod 16, a diagonal skew so that column-wise reads hit distinct banks. sel_in and wr_en follow the skewed bank; wr_addr is unchanged.
- BANK_SKEW_EN undefined: bank = col. No adder is instantiated.

## Test plan
- Reset then idle, DEPTH=16: hold rst_n=0 for 3 cycles, release, drive in_valid=1 with no start → wr_en=0, in_ready=0, busy=0 throughout.
- Full frame, no skew, DEPTH=16: start, then 256 words D_in=0..255 back-to-back → word k gives wr_en=1<<(k%16) and wr_addr=k/16 one cycle later. Last write: wr_en=16'h8000, wr_addr=15, wr_data=255, done=1 in that cycle.
- Backpressure gaps: same frame with in_valid low on every third cycle → no wr_en in the cycle after each gap. Final bank/address contents are identical to the back-to-back test; done fires after exactly 256 accepts.
- Abort: start, accept 20 words, assert start together with in_valid=1 → in_ready=0 that cycle and no write follows. The next accepted word writes bank 0, row 0.
- Skew (BANK_SKEW_EN defined, DEPTH=16): word 17 (row 1, col 1) → wr_en=16'h0004, sel_in=2, wr_addr=1. Word 255 → wr_en=16'h4000, wr_addr=15.
- Async reset mid-frame: pull rst_n low between clock edges at word 100 → wr_en and busy go to 0 immediately. After release, no done is issued until a new start and 256 accepts.
